// File: rtl/cpu_issue_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_issue_seq_if
//
// Groups the two buses around the issue sequencer:
//   - the instruction byte stream from upstream (valid/ready handshake)
//   - the operand/result path to and from the 4-bit ALU
//
// Signals:
//   instr_byte  [7:0]  instruction or immediate byte from upstream
//   instr_valid        instr_byte is valid
//   instr_ready        sequencer accepts instr_byte this cycle
//   alu_opcode  [2:0]  ALU opcode
//   alu_in_1    [3:0]  ALU first operand  (R[rd])
//   alu_in_2    [3:0]  ALU second operand (R[rs] or immediate)
//   alu_en             ALU enable
//   alu_out     [3:0]  ALU result
//
// Modports:
//   master : environment side (instruction source + ALU)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface cpu_issue_seq_if;
  logic [7:0] instr_byte;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] alu_opcode;
  logic [3:0] alu_in_1;
  logic [3:0] alu_in_2;
  logic       alu_en;
  logic [3:0] alu_out;

  modport master (
    output instr_byte,
    output instr_valid,
    input  instr_ready,
    input  alu_opcode,
    input  alu_in_1,
    input  alu_in_2,
    input  alu_en,
    output alu_out
  );

  modport slave (
    input  instr_byte,
    input  instr_valid,
    output instr_ready,
    output alu_opcode,
    output alu_in_1,
    output alu_in_2,
    output alu_en,
    input  alu_out
  );
endinterface : cpu_issue_seq_if

// File: rtl/cpu_issue_seq.sv
// -----------------------------------------------------------------------------
// cpu_issue_seq
//
// Instruction issue sequencer in front of the 4-bit ALU. Accepts instruction
// bytes over a valid/ready handshake, reads operands from a 4x4-bit register
// file, drives the ALU for ALU_LAT cycles and writes the result back into the
// destination register.
//
// Instruction byte: [7:5] op, [4:3] rd, [2:1] rs, [0] I.
//   I=1: a second byte follows; its [3:0] is the immediate, [7:4] ignored.
//
// Sequence: FETCH -> (IMM) -> EXEC -> (WAIT x ALU_LAT-1) -> WB -> FETCH
//
// Parameters:
//   ALU_LAT  cycles from first ALU-enabled cycle to the cycle alu_out is
//            sampled (1..7)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena        design enable; when 0 the block is frozen
//   bus        instruction handshake + ALU bus (slave modport)
//   retire     one-cycle pulse in the writeback cycle
//   busy       high in every state except FETCH
//   zero_flag  result-was-zero flag, updated in writeback
//   dbg_sel    register readback select
//   dbg_data   combinational R[dbg_sel]
//
// Configuration macro:
//   ISSUE_ZERO_FLAG_EN  when defined, zero_flag is a register updated on
//                       every writeback; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module cpu_issue_seq #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  cpu_issue_seq_if.slave        bus,
  output logic                  retire,
  output logic                  busy,
  output logic                  zero_flag,
  input  logic [1:0]            dbg_sel,
  output logic [3:0]            dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IMM   = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;

  // Fields that must survive past the fetch cycle. rs and I are consumed in
  // the fetch cycle itself (operand select / next-state choice), so only the
  // opcode and destination are kept.
  logic [2:0] op_q;
  logic [1:0] rd_q;

  // Registered ALU drive; loaded only on entry to EXEC, held otherwise.
  logic [2:0] opcode_q, opcode_d;
  logic [3:0] in1_q,    in1_d;
  logic [3:0] in2_q,    in2_d;
  logic       ops_load;

  logic       fetch_hs;
  logic       wb_we;

  logic [3:0] regs_q [4];

  // ---------------------------------------------------------------------------
  // Next-state / output decode. Everything is gated by ena so that a frozen
  // block neither advances nor handshakes nor drives the ALU.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    opcode_d        = opcode_q;
    in1_d           = in1_q;
    in2_d           = in2_q;
    ops_load        = 1'b0;
    fetch_hs        = 1'b0;
    wb_we           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.alu_en      = 1'b0;
    retire          = 1'b0;

    if (ena) begin
      unique case (state_q)
        S_FETCH: begin
          bus.instr_ready = 1'b1;
          if (bus.instr_valid) begin
            fetch_hs = 1'b1;
            if (bus.instr_byte[0]) begin
              state_d = S_IMM;
            end else begin
              // Register form: operands come straight from the byte being
              // accepted, since op/rd/rs are not latched yet.
              state_d  = S_EXEC;
              ops_load = 1'b1;
              opcode_d = bus.instr_byte[7:5];
              in1_d    = regs_q[bus.instr_byte[4:3]];
              in2_d    = regs_q[bus.instr_byte[2:1]];
            end
          end
        end

        S_IMM: begin
          bus.instr_ready = 1'b1;
          if (bus.instr_valid) begin
            state_d  = S_EXEC;
            ops_load = 1'b1;
            opcode_d = op_q;
            in1_d    = regs_q[rd_q];
            in2_d    = bus.instr_byte[3:0];
          end
        end

        S_EXEC: begin
          bus.alu_en = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = (ALU_LAT == 1) ? S_WB : S_WAIT;
        end

        S_WAIT: begin
          bus.alu_en = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          // Leave on the cycle the counter reaches zero; <= also guards
          // against a stray zero so the FSM can never stall here.
          if (cnt_q <= 3'd1) begin
            state_d = S_WB;
          end
        end

        S_WB: begin
          retire  = 1'b1;
          wb_we   = 1'b1;
          state_d = S_FETCH;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= S_FETCH;
      cnt_q    <= 3'd0;
      op_q     <= 3'd0;
      rd_q     <= 2'd0;
      opcode_q <= 3'd0;
      in1_q    <= 4'd0;
      in2_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fetch_hs) begin
        op_q <= bus.instr_byte[7:5];
        rd_q <= bus.instr_byte[4:3];
      end
      if (ops_load) begin
        opcode_q <= opcode_d;
        in1_q    <= in1_d;
        in2_q    <= in2_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the register file is architecturally cleared by reset, so it is
    // built from resettable flops rather than an inferred RAM.
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 4'd0;
      end
    end else if (wb_we) begin
      regs_q[rd_q] <= bus.alu_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Zero flag
  // ---------------------------------------------------------------------------
`ifdef ISSUE_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (wb_we) begin
      zero_q <= (bus.alu_out == 4'h0);
    end
  end

  assign zero_flag = zero_q;
`else
  assign zero_flag = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_in_1   = in1_q;
  assign bus.alu_in_2   = in2_q;
  assign busy           = (state_q != S_FETCH);

  // Reads the current contents, so in the WB cycle R[rd] still shows the
  // old value; the written value appears the following cycle.
  assign dbg_data = regs_q[dbg_sel];

endmodule : cpu_issue_seq

// File: tb/tb_cpu_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_issue_seq
//
// Self-checking bench for cpu_issue_seq (ALU_LAT=3). The bench plays both the
// instruction source and the ALU. A register-file model predicts the operands
// and write-back of every instruction at the time it is issued; predictions
// are queued and popped as the DUT executes and retires them.
// Honors ISSUE_ZERO_FLAG_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_cpu_issue_seq;

  localparam int unsigned ALU_LAT = 3;
  localparam int          TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] dbg_data;
  logic       retire;
  logic       busy;
  logic       zero_flag;

  cpu_issue_seq_if bus ();

  cpu_issue_seq #(.ALU_LAT(ALU_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (bus),
    .retire    (retire),
    .busy      (busy),
    .zero_flag (zero_flag),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] old;
    logic [3:0] res;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mreg[4];
  logic       mzf;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Model: compute operands from the current model state, then apply the
  // write-back so later predictions see it.
  task automatic predict(input logic [7:0] b0, input logic [7:0] b1, input logic [3:0] res);
    exp_t e;
    e.op  = b0[7:5];
    e.rd  = b0[4:3];
    e.in1 = mreg[b0[4:3]];
    e.in2 = b0[0] ? b1[3:0] : mreg[b0[2:1]];
    e.old = mreg[b0[4:3]];
    e.res = res;
    exp_q.push_back(e);
    mreg[e.rd] = res;
  endtask

  // Present a byte and wait (bounded) for the handshake edge; returns at the
  // negedge after the accepting posedge with instr_valid dropped.
  task automatic send_byte(input logic [7:0] b, input string tag);
    int n = 0;
    bus.instr_byte  = b;
    bus.instr_valid = 1'b1;
    while (bus.instr_ready !== 1'b1 && n < TIMEOUT) begin
      cyc();
      n++;
    end
    vectors++;
    if (n >= TIMEOUT) begin
      miscompares++;
      $display("FAIL %s_accept: instr_ready=%b after %0d cycles, required 1", tag, bus.instr_ready, n);
    end
    cyc();
    bus.instr_valid = 1'b0;
  endtask

  // Called at the negedge of the EXEC cycle. Checks EXEC, WAIT, WB and the
  // following FETCH cycle. freeze_at>0 drops ena for 5 cycles after that
  // many WAIT cycles. pend presents the next byte during execution.
  task automatic execute(input string tag, input int freeze_at, input bit pend, input logic [7:0] pend_byte);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_queue: scoreboard empty at EXEC, required 1 entry", tag);
      return;
    end
    e = exp_q[0];
    bus.alu_out = e.res;
    if (pend) begin
      bus.instr_byte  = pend_byte;
      bus.instr_valid = 1'b1;
    end

    vectors++;
    if ({bus.alu_en, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2, busy, bus.instr_ready, retire}
        !== {1'b1, e.op, e.in1, e.in2, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_exec: en/op/in1/in2/busy/rdy/ret=%b/%h/%h/%h/%b/%b/%b required 1/%h/%h/%h/1/0/0",
               tag, bus.alu_en, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2, busy, bus.instr_ready, retire,
               e.op, e.in1, e.in2);
    end

    for (int k = 1; k < int'(ALU_LAT); k++) begin
      cyc();
      vectors++;
      if ({bus.alu_en, bus.alu_in_1, bus.alu_in_2, bus.instr_ready, retire}
          !== {1'b1, e.in1, e.in2, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL %s_wait%0d: en/in1/in2/rdy/ret=%b/%h/%h/%b/%b required 1/%h/%h/0/0",
                 tag, k, bus.alu_en, bus.alu_in_1, bus.alu_in_2, bus.instr_ready, retire, e.in1, e.in2);
      end
      if (k == freeze_at) begin
        ena = 1'b0;
        for (int f = 0; f < 5; f++) begin
          cyc();
          vectors++;
          if ({bus.alu_en, bus.instr_ready, retire, busy, bus.alu_in_1, bus.alu_in_2}
              !== {1'b0, 1'b0, 1'b0, 1'b1, e.in1, e.in2}) begin
            miscompares++;
            $display("FAIL %s_frozen%0d: en/rdy/ret/busy/in1/in2=%b/%b/%b/%b/%h/%h required 0/0/0/1/%h/%h",
                     tag, f, bus.alu_en, bus.instr_ready, retire, busy, bus.alu_in_1, bus.alu_in_2,
                     e.in1, e.in2);
          end
        end
        ena = 1'b1;
      end
    end

    cyc();
    dbg_sel = e.rd;
    #1;
    vectors++;
    if ({retire, bus.alu_en, bus.instr_ready, busy, dbg_data} !== {1'b1, 1'b0, 1'b0, 1'b1, e.old}) begin
      miscompares++;
      $display("FAIL %s_wb: ret/en/rdy/busy/dbg=%b/%b/%b/%b/%h required 1/0/0/1/%h",
               tag, retire, bus.alu_en, bus.instr_ready, busy, dbg_data, e.old);
    end

`ifdef ISSUE_ZERO_FLAG_EN
    mzf = (e.res == 4'h0);
`endif

    cyc();
    e = exp_q.pop_front();
    vectors++;
    if ({retire, busy, bus.instr_ready, dbg_data, zero_flag} !== {1'b0, 1'b0, 1'b1, e.res, mzf}) begin
      miscompares++;
      $display("FAIL %s_fetch: ret/busy/rdy/dbg/zf=%b/%b/%b/%h/%b required 0/0/1/%h/%b",
               tag, retire, busy, bus.instr_ready, dbg_data, zero_flag, e.res, mzf);
    end
  endtask

  task automatic issue(input logic [7:0] b0, input logic [7:0] b1, input logic [3:0] res, input string tag);
    predict(b0, b1, res);
    send_byte(b0, tag);
    if (b0[0]) begin
      vectors++;
      if ({busy, bus.alu_en, bus.instr_ready} !== 3'b101) begin
        miscompares++;
        $display("FAIL %s_imm_state: busy/en/rdy=%b/%b/%b required 1/0/1", tag, busy, bus.alu_en, bus.instr_ready);
      end
      send_byte(b1, tag);
    end
    execute(tag, 0, 1'b0, 8'h00);
  endtask

  task automatic check_all_regs_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      vectors++;
      if (dbg_data !== 4'h0) begin
        miscompares++;
        $display("FAIL %s_r%0d: dbg_data=%h required 0", tag, i, dbg_data);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    cyc();
    cyc();
    vectors++;
    if ({busy, bus.alu_en, retire, bus.instr_ready, zero_flag, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy/en/ret/rdy/zf/op/in1/in2=%b/%b/%b/%b/%b/%h/%h/%h required all 0",
               busy, bus.alu_en, retire, bus.instr_ready, zero_flag, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2);
    end
    check_all_regs_zero("reset");
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (bus.instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_ena0: instr_ready=%b required 0", bus.instr_ready);
    end
    ena = 1'b1;
    #1;
    vectors++;
    if (bus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_ena1: instr_ready=%b required 1", bus.instr_ready);
    end
    cyc();
  endtask

  task automatic test_immediate();
    // op=0 rd=1 I=1, immediate byte 0x35: upper nibble must be dropped.
    issue(8'h09, 8'h35, 4'h5, "imm");
  endtask

  task automatic test_register();
    // op=2 rd=0 rs=1: in_1=R0=0, in_2=R1=5.
    issue(8'h42, 8'h00, 4'hA, "reg");
    // op=3 rd=rs=1: both operands are R1.
    issue(8'h6A, 8'h00, 4'h7, "rd_eq_rs");
  endtask

  task automatic test_stall();
    // op=3 rd=1 I=1, then 10 idle cycles in IMM before immediate 0xF2.
    predict(8'h6B, 8'hF2, 4'h9);
    send_byte(8'h6B, "stall");
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({busy, bus.alu_en, bus.instr_ready, retire} !== 4'b1010) begin
        miscompares++;
        $display("FAIL stall_imm%0d: busy/en/rdy/ret=%b/%b/%b/%b required 1/0/1/0",
                 i, busy, bus.alu_en, bus.instr_ready, retire);
      end
      cyc();
    end
    send_byte(8'hF2, "stall");
    execute("stall", 0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    // Second byte is presented during the first instruction and must only be
    // taken in the next FETCH.
    predict(8'h20, 8'h00, 4'h3);
    predict(8'hB6, 8'h00, 4'hC);
    send_byte(8'h20, "b2b_a");
    execute("b2b_a", 0, 1'b1, 8'hB6);
    cyc();
    bus.instr_valid = 1'b0;
    execute("b2b_b", 0, 1'b0, 8'h00);
  endtask

  task automatic test_ena_freeze();
    predict(8'h18, 8'h00, 4'h6);
    send_byte(8'h18, "freeze");
    execute("freeze", 1, 1'b0, 8'h00);
  endtask

  task automatic test_zero_flag();
    issue(8'h00, 8'h00, 4'h0, "zf_set");
    issue(8'h08, 8'h00, 4'h3, "zf_clr");
  endtask

  task automatic test_reset_mid_wait();
    predict(8'h50, 8'h00, 4'hF);
    send_byte(8'h50, "rst_wait");
    cyc();
    vectors++;
    if ({busy, bus.alu_en} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_wait_in_wait: busy/en=%b/%b required 1/1", busy, bus.alu_en);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, bus.alu_en, retire, zero_flag, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2} !== '0) begin
      miscompares++;
      $display("FAIL rst_wait_outputs: busy/en/ret/zf/op/in1/in2=%b/%b/%b/%b/%h/%h/%h required all 0",
               busy, bus.alu_en, retire, zero_flag, bus.alu_opcode, bus.alu_in_1, bus.alu_in_2);
    end
    check_all_regs_zero("rst_wait");
    for (int i = 0; i < 4; i++) mreg[i] = 4'h0;
    exp_q.delete();
    mzf = 1'b0;
    ena = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    ena = 1'b1;
    #1;
    vectors++;
    if ({bus.instr_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_wait_release: rdy/busy=%b/%b required 1/0", bus.instr_ready, busy);
    end
    cyc();
    // The discarded instruction must not resume; R1 restarts from 0.
    issue(8'h09, 8'hE4, 4'h4, "post_rst");
  endtask

  initial begin
    bus.instr_byte  = 8'h00;
    bus.instr_valid = 1'b0;
    bus.alu_out     = 4'h0;
    for (int i = 0; i < 4; i++) mreg[i] = 4'h0;
    mzf = 1'b0;

    test_reset();
    test_immediate();
    test_register();
    test_stall();
    test_back_to_back();
    test_ena_freeze();
    test_zero_flag();
    test_reset_mid_wait();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
    $fatal(1);
  end

endmodule : tb_cpu_issue_seq
